// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: a small byte FIFO feeding an 8N1 serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (0)
// DATA   | 8 data bits, LSB first
// PARITY | even parity of the data byte (UART_TX_PARITY_EN only)
// STOP   | stop bit (1); chains straight into START if more bytes are queued
module uart_tx_buf #(
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic                          tx_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic [15:0]   bit_cnt;
    logic          bit_tc;
    logic          push;
    logic          pop;
    logic          line_bit;

    assign din_ready = (fifo_count != CW'(FIFO_DEPTH));
    assign busy      = (state != IDLE) || (fifo_count != '0);
    assign bit_tc    = (bit_cnt == '0);
    assign push      = din_valid && din_ready;
    // A byte leaves the FIFO only when the serializer loads it.
    assign pop       = (fifo_count != '0) &&
                       ((state == IDLE) || ((state == STOP) && bit_tc));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Line level for the current state; registered below, so the line trails the state by one cycle.
    always_comb begin
        line_bit = 1'b1;
        case (state)
            START:   line_bit = 1'b0;
            DATA:    line_bit = shreg[bit_idx];
`ifdef UART_TX_PARITY_EN
            PARITY:  line_bit = ^shreg;
`endif
            default: line_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            bit_cnt <= '0;
            tx_data <= 1'b1;
        end else begin
            tx_data <= line_bit;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state   <= START;
                        shreg   <= mem[rd_ptr];
                        bit_cnt <= RELOAD;
                    end
                end
                START: begin
                    if (bit_tc) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        bit_cnt <= RELOAD;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_tc) begin
                        bit_cnt <= RELOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_tc) begin
                        state   <= STOP;
                        bit_cnt <= RELOAD;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_tc) begin
                        if (pop) begin
                            state   <= START;
                            shreg   <= mem[rd_ptr];
                            bit_cnt <= RELOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
